// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: operation encodings,
// FSM state type and small decode helpers.
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;  // signed quotient
  localparam logic [1:0] OP_MOD  = 2'b01;  // signed remainder
  localparam logic [1:0] OP_DIVU = 2'b10;  // unsigned quotient
  localparam logic [1:0] OP_MODU = 2'b11;  // unsigned remainder

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) | (op == OP_MOD);
  endfunction

  function automatic logic op_is_mod(input logic [1:0] op);
    return (op == OP_MOD) | (op == OP_MODU);
  endfunction

endpackage

// File: rtl/iter_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder, trial-subtract the divisor and produce the
// next quotient bit. The dividend register doubles as the quotient register.
module iter_div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] diff_s;
  logic             fits_s;

  // Trial subtraction; the W-bit difference is exact whenever the divisor fits.
  always_comb begin
    rem_sh_s = {rem, quo[WIDTH-1]};
    fits_s   = (rem_sh_s >= {1'b0, dvsr});
    diff_s   = rem_sh_s[WIDTH-1:0] - dvsr;
    if (fits_s) begin
      rem_next = diff_s;
    end else begin
      rem_next = rem_sh_s[WIDTH-1:0];
    end
    quo_next = {quo[WIDTH-2:0], fits_s};
  end

endmodule

// File: rtl/iter_div.sv
// Iterative restoring divider, one quotient bit per cycle, with a tag
// sideband and ready/valid handshakes on both sides.
// Optional macro ITER_DIV_EARLY_OUT_EN: skip the iteration when the divisor
// is zero or |dividend| < |divisor| and present the result one edge later.
module iter_div
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             mod_q, mod_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic             accept_s, sgn_s, dvsr_zero_s, early_s;
  logic [WIDTH-1:0] mag1_s, mag2_s, early_res_s, final_res_s;
  logic [WIDTH-1:0] step_rem_s, step_quo_s;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    if (is_signed & v[WIDTH-1]) begin
      return negate(v);
    end else begin
      return v;
    end
  endfunction

  assign in_ready   = ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready)) & ~flush;
  assign accept_s   = in_valid & in_ready;
  assign out_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign out_result = res_q;
  assign out_tag    = tag_q;

  iter_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvsr     (dvsr_q),
    .rem_next (step_rem_s),
    .quo_next (step_quo_s)
  );

  // Decode the incoming request: operand magnitudes and shortcut eligibility.
  always_comb begin
    sgn_s       = op_is_signed(in_op);
    mag1_s      = magnitude(in_src1, sgn_s);
    mag2_s      = magnitude(in_src2, sgn_s);
    dvsr_zero_s = (in_src2 == {WIDTH{1'b0}});
`ifdef ITER_DIV_EARLY_OUT_EN
    early_s = dvsr_zero_s | (mag1_s < mag2_s);
    if (op_is_mod(in_op)) begin
      early_res_s = in_src1;
    end else if (dvsr_zero_s) begin
      early_res_s = {WIDTH{1'b1}};
    end else begin
      early_res_s = {WIDTH{1'b0}};
    end
`else
    early_s     = 1'b0;
    early_res_s = {WIDTH{1'b0}};
`endif
  end

  // Sign-correct the last step's quotient or remainder into the final result.
  always_comb begin
    if (mod_q) begin
      final_res_s = rneg_q ? negate(step_rem_s) : step_rem_s;
    end else begin
      final_res_s = qneg_q ? negate(step_quo_s) : step_quo_s;
    end
  end

  // Next-state logic: flush first, then accept, then per-state progress.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    res_d   = res_q;
    tag_d   = tag_q;
    mod_d   = mod_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_d  = {CNT_W{1'b0}};
      rem_d  = {WIDTH{1'b0}};
      quo_d  = mag1_s;
      dvsr_d = mag2_s;
      tag_d  = in_tag;
      mod_d  = op_is_mod(in_op);
      // A zero divisor keeps the all-ones quotient unsigned-looking.
      qneg_d = sgn_s & (in_src1[WIDTH-1] ^ in_src2[WIDTH-1]) & ~dvsr_zero_s;
      rneg_d = sgn_s & in_src1[WIDTH-1];
      if (early_s) begin
        state_d = ST_DONE;
        res_d   = early_res_s;
      end else begin
        state_d = ST_CALC;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_CALC: begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
            cnt_d   = {CNT_W{1'b0}};
            res_d   = final_res_s;
          end else begin
            state_d = ST_CALC;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      quo_q   <= {WIDTH{1'b0}};
      dvsr_q  <= {WIDTH{1'b0}};
      res_q   <= {WIDTH{1'b0}};
      tag_q   <= {TAG_W{1'b0}};
      mod_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      mod_q   <= mod_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule

// File: tb/tb_iter_div.sv
// Scoreboard bench for iter_div: the stimulus side pushes expected results
// as requests are accepted; a monitor pops and compares on every output.
module tb_iter_div;
  import div_pkg::*;

  localparam int W  = 32;
  localparam int TW = 5;

  logic          clk, resetn, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]    in_op;
  logic [W-1:0]  in_src1, in_src2, out_result;
  logic [TW-1:0] in_tag, out_tag;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    int            acc;
    int            lat;
    bit            seen;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   rand_rdy = 1'b0;

  iter_div #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  // Reference model: plain arithmetic with the divide-by-zero / overflow rules.
  function automatic logic [W-1:0] ref_res(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic signed [W-1:0] sa, sbv;
    logic [W-1:0] q, r;
    sa = a;
    sbv = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!op[1] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (!op[1]) begin
      q = sa / sbv; r = sa % sbv;
    end else begin
      q = a / b; r = a % b;
    end
    return op[0] ? r : q;
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
`ifdef ITER_DIV_EARLY_OUT_EN
    logic [W-1:0] ma, mb;
    ma = (!op[1] && a[W-1]) ? 32'd0 - a : a;
    mb = (!op[1] && b[W-1]) ? 32'd0 - b : b;
    return (b == 32'd0 || ma < mb) ? 1 : W;
`else
    return (op == op && a == a && b == b) ? W : W;
`endif
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      5: return 32'($urandom_range(0, 65535));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Present a request; record the expectation at the edge where it is taken.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, input logic [W-1:0] res);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = res; e.tag = tag; e.acc = cyc + 1; e.lat = exp_lat(op, a, b); e.seen = 1'b0;
        exp_q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("drain_timeout", 32'(ok), 32'd1);
    if (!ok) exp_q.delete();
    @(posedge clk); #1;
  endtask

  // Monitor: compare every presented output against the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (resetn && out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_valid: got result %h tag %h, required no output", out_result, out_tag);
      end else begin
        check("result", out_result, exp_q[0].res);
        check("tag", 32'(out_tag), 32'(exp_q[0].tag));
        if (!exp_q[0].seen) check("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
        exp_q[0].seen = 1'b1;
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    logic [1:0] op;
    logic [W-1:0] a, b;
    bit seen_v;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 2'b00; in_src1 = 32'd0; in_src2 = 32'd0; in_tag = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1; out_ready = 1'b1;

    // Directed arithmetic cases, including the boundary rules.
    issue(OP_DIVU, 32'd100, 32'd7, 5'h01, 32'd14);
    issue(OP_MODU, 32'd100, 32'd7, 5'h02, 32'd2);
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'h13, 32'hFFFF_FFFD);
    issue(OP_MOD,  32'hFFFF_FFF9, 32'd2, 5'h13, 32'hFFFF_FFFF);
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'h0A, 32'h8000_0000);
    issue(OP_MOD,  32'h8000_0000, 32'hFFFF_FFFF, 5'h0B, 32'd0);
    issue(OP_DIVU, 32'd5, 32'd0, 5'h0C, 32'hFFFF_FFFF);
    issue(OP_MODU, 32'd5, 32'd0, 5'h0D, 32'd5);
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd0, 5'h0E, 32'hFFFF_FFFF);
    issue(OP_MOD,  32'hFFFF_FFF9, 32'd0, 5'h0F, 32'hFFFF_FFF9);
    issue(OP_DIVU, 32'd3, 32'd10, 5'h10, 32'd0);
    issue(OP_MOD,  32'hFFFF_FFFD, 32'd10, 5'h11, 32'hFFFF_FFFD);
    drain();

    // Flush in the middle of the iteration with a competing request.
    issue(OP_DIVU, 32'd1000, 32'd3, 5'h04, 32'd333);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; in_op = OP_DIVU; in_src1 = 32'd50; in_src2 = 32'd5;
    void'(exp_q.pop_back());
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_flush_in_ready", 32'(in_ready), 32'd1);
    check("post_flush_busy", 32'(busy), 32'd0);
    check("post_flush_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    issue(OP_DIVU, 32'd9, 32'd3, 5'h05, 32'd3);
    drain();

    // Stall in DONE, then hand over to a new request on the same edge.
    out_ready = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 5'h06, 32'd14);
    seen_v = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen_v = 1'b1;
        break;
      end
    end
    check("stall_valid_seen", 32'(seen_v), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_result", out_result, 32'd14);
      check("stall_tag", 32'(out_tag), 32'h06);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(OP_MODU, 32'd100, 32'd7, 5'h07, 32'd2);
    for (int k = 0; k < 4; k++) begin
      check("b2b_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    drain();

    // Reset aborts an operation in flight.
    issue(OP_DIVU, 32'd77, 32'd5, 5'h08, 32'd15);
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", out_result, 32'd0);
    @(posedge clk); #1;

    // Randomised traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 200; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      issue(op, a, b, 5'($urandom_range(0, 31)), ref_res(op, a, b));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_div.md
ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (>=8, even).
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag (destination register).
REQ-003 SHALL have port clk  input  1  clock; resetn, synchronous, active-low; clock clk.
REQ-004 SHALL have port resetn  input  1  synchronous active-low reset.
REQ-005 SHALL have port flush  input  1  discard any operation in flight.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  request accepted when in_valid & in_ready.
REQ-008 SHALL have port in_op  input  2  00 div signed, 01 mod signed, 10 div unsigned, 11 mod unsigned.
REQ-009 SHALL have ports in_src1 / in_src2  input  WIDTH  dividend / divisor.
REQ-010 SHALL have port in_tag  input  TAG_W  sideband carried to output unchanged.
REQ-011 SHALL have ports out_valid  output  1, out_ready  input  1  result handshake.
REQ-012 SHALL have ports out_result  output  WIDTH and out_tag  output  TAG_W.
REQ-013 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> DONE; IDLE->CALC on accept; CALC->DONE after last step; DONE->IDLE on out_ready without new accept.
REQ-015 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready) & ~flush.
REQ-016 SHALL, in DONE with out_ready & in_valid, accept the new request on the same edge and enter CALC (back-to-back, no bubble).
REQ-017 SHALL latch op, tag, operand magnitudes and result signs on the accepting edge.
REQ-018 SHALL perform one restoring step per cycle in CALC, iteration counter 0..WIDTH-1.
REQ-019 SHALL assert out_valid exactly WIDTH clock edges after the accepting edge (full-length path).
REQ-020 SHALL hold out_result, out_tag, out_valid stable while out_valid & ~out_ready.
REQ-021 SHALL, for signed ops, divide magnitudes; quotient negated when signs differ; remainder takes dividend sign.
REQ-022 SHALL return quotient 0x80..0 and remainder 0 for signed MIN / -1 (no trap).
REQ-023 SHALL return quotient all-ones and remainder = in_src1 for divisor 0, any signedness.
REQ-024 SHALL, on flush, go to IDLE on the next edge with out_valid low; flush wins over simultaneous accept and over out_ready.
REQ-025 SHALL keep out_valid low in IDLE and CALC.

Reset
REQ-026 SHALL, on resetn low at a clk edge, set state IDLE, counter 0, out_valid 0, busy 0, out_result 0, out_tag 0; in_ready 1 after reset.
REQ-027 SHALL abort any in-flight operation on reset with no output produced.

Configuration
REQ-028 SHALL honour macro ITER_DIV_EARLY_OUT_EN.
REQ-029 SHALL, with ITER_DIV_EARLY_OUT_EN defined, go from accept directly to DONE (out_valid one edge after accept) when divisor is 0 or |src1| < |src2|, results per REQ-021/023.
REQ-030 SHALL, without the macro, take the full WIDTH-edge latency for every operation.

Structure
REQ-031 SHALL place op encodings (OP_DIV, OP_MOD, OP_DIVU, OP_MODU) and the state enum in shared package div_pkg.
REQ-032 SHALL place one combinational restoring step (shift, trial subtract, quotient bit) in sub-module iter_div_step.

Verification
REQ-033 SHALL test divu 100/7 -> out_result 14, out_valid 32 edges after accept; modu 100/7 -> 2.
REQ-034 SHALL test div signed 0xFFFFFFF9/2 -> 0xFFFFFFFD; mod -> 0xFFFFFFFF; tag 5'h13 echoed.
REQ-035 SHALL test div signed 0x80000000/0xFFFFFFFF -> 0x80000000, mod -> 0; divu 5/0 -> 0xFFFFFFFF, modu 5/0 -> 5.
REQ-036 SHALL test flush at CALC iteration 10 with in_valid high -> no out_valid, in_ready high next cycle, following divu 9/3 -> 3.
REQ-037 SHALL test out_ready low 5 cycles in DONE -> result stable; then out_ready with in_valid -> new op accepted same edge, busy never drops.
REQ-038 SHALL test, with ITER_DIV_EARLY_OUT_EN, divu 3/10 -> 0 one edge after accept; without macro -> 0 after 32 edges.
